// File: rtl/fastbconv_sched.sv
// fastbconv_sched: job scheduler for a shared fast base-conversion datapath.
// Requesters are granted round-robin; each job runs IN_BASIS_LEN accumulate
// steps and the result is held until the consumer takes it. A consumer take
// and a new grant may share one edge, so jobs can run back-to-back.
module fastbconv_sched #(
    parameter int IN_BASIS_LEN = 4,
    parameter int N_REQ        = 2,
    localparam int SW = (IN_BASIS_LEN > 1) ? $clog2(IN_BASIS_LEN) : 1,
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req_valid,
    output logic [N_REQ-1:0] req_ready,
    output logic             a_latch_en,
    output logic             acc_clear,
    output logic             acc_en,
    output logic [SW-1:0]    step_idx,
    output logic [IW-1:0]    owner_id,
    output logic             busy,
    output logic             done_valid,
    output logic [IW-1:0]    done_id,
    input  logic             done_ready
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [SW-1:0] LAST_STEP = SW'(IN_BASIS_LEN - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [SW-1:0] r_cnt;
    logic [IW-1:0] r_rr_ptr;
    logic [IW-1:0] r_owner;
    logic [IW-1:0] w_gnt;
    logic [IW-1:0] w_rr_nxt;
    logic          w_any_req;
    logic          w_accept;
    logic          w_last_step;

    // Round-robin pick: the valid requester closest above rr_ptr (with wrap).
    always_comb begin
        int v_dist;
        int v_best;
        v_dist = 0;
        v_best = N_REQ;
        w_gnt  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            v_dist = (i + N_REQ - int'(r_rr_ptr)) % N_REQ;
            if (req_valid[i] && (v_dist < v_best)) begin
                v_best = v_dist;
                w_gnt  = IW'(i);
            end
        end
    end

    // Accept only when the datapath is free (idle, or result being taken now).
    always_comb begin
        w_any_req   = |req_valid;
        w_last_step = (r_cnt == LAST_STEP);
        w_accept    = !reset && w_any_req &&
                      ((r_state == ST_IDLE) || ((r_state == ST_DONE) && done_ready));
        w_rr_nxt    = IW'((int'(w_gnt) + 1) % N_REQ);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (w_last_step) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (done_ready) w_state_nxt = w_accept ? ST_ACCUM : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Step counter, round-robin pointer and job owner.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_rr_ptr <= '0;
            r_owner  <= '0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_rr_ptr <= w_rr_nxt;
            r_owner  <= w_gnt;
        end else if (r_state == ST_ACCUM) begin
            r_cnt    <= w_last_step ? '0 : r_cnt + SW'(1);
        end
    end

    // Output decode: grant strobes from the accept term, the rest from state.
    always_comb begin
        req_ready  = w_accept ? (N_REQ'(1) << w_gnt) : '0;
        a_latch_en = w_accept;
        acc_clear  = w_accept;
        acc_en     = (r_state == ST_ACCUM);
        step_idx   = (r_state == ST_ACCUM) ? r_cnt : '0;
        owner_id   = r_owner;
        busy       = (r_state != ST_IDLE);
        done_valid = (r_state == ST_DONE);
        done_id    = r_owner;
    end

endmodule

// File: tb/tb_fastbconv_sched.sv
// Bench for fastbconv_sched: two instances (4 steps / 2 requesters and
// 1 step / 1 requester) checked every cycle against a job-timeline model.
module tb_fastbconv_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: IN_BASIS_LEN=4, N_REQ=2
    logic       rst0, dr0;
    logic [1:0] rv0, rr0;
    logic       al0, ac0, ae0, b0, dv0;
    logic [1:0] si0;
    logic [0:0] oi0, di0;

    // Instance 1: IN_BASIS_LEN=1, N_REQ=1
    logic       rst1, dr1;
    logic [0:0] rv1, rr1;
    logic       al1, ac1, ae1, b1, dv1;
    logic [0:0] si1;
    logic [0:0] oi1, di1;

    fastbconv_sched #(.IN_BASIS_LEN(4), .N_REQ(2)) dut0 (
        .clk(clk), .reset(rst0), .req_valid(rv0), .req_ready(rr0),
        .a_latch_en(al0), .acc_clear(ac0), .acc_en(ae0), .step_idx(si0),
        .owner_id(oi0), .busy(b0), .done_valid(dv0), .done_id(di0),
        .done_ready(dr0)
    );

    fastbconv_sched #(.IN_BASIS_LEN(1), .N_REQ(1)) dut1 (
        .clk(clk), .reset(rst1), .req_valid(rv1), .req_ready(rr1),
        .a_latch_en(al1), .acc_clear(ac1), .acc_en(ae1), .step_idx(si1),
        .owner_id(oi1), .busy(b1), .done_valid(dv1), .done_id(di1),
        .done_ready(dr1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: a job is described by the cycle it was accepted in.
    int Lp[2] = '{4, 1};
    int Np[2] = '{2, 1};
    int m_start[2];
    int m_owner[2];
    int m_rr[2];
    int m_cyc;

    int         q_gnt[$];
    logic [1:0] last_rr0;
    logic       last_ac0, last_al0;
    logic [1:0] last_si0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, m_cyc);
        end
    endtask

    task automatic model_eval(input int d, input logic rst, input int rv, input logic dr,
                              input int o_rr, input int o_al, input int o_ac, input int o_ae,
                              input int o_si, input int o_oi, input int o_b, input int o_dv,
                              input int o_di, output bit acc, output int g, output bit rel);
        int  age;
        bit  idle, accum, done, found;
        idle  = (m_start[d] < 0);
        age   = m_cyc - m_start[d];
        accum = !idle && (age <= Lp[d]);
        done  = !idle && (age > Lp[d]);
        g     = 0;
        found = 0;
        for (int k = 0; k < Np[d]; k++) begin
            int c;
            c = (m_rr[d] + k) % Np[d];
            if (!found && (((rv >> c) & 1) == 1)) begin
                found = 1;
                g     = c;
            end
        end
        acc = !rst && (idle || (done && dr)) && (rv != 0);
        rel = !rst && done && dr;
        chk($sformatf("d%0d_req_ready", d), o_rr, acc ? (1 << g) : 0);
        chk($sformatf("d%0d_a_latch_en", d), o_al, int'(acc));
        chk($sformatf("d%0d_acc_clear", d), o_ac, int'(acc));
        chk($sformatf("d%0d_acc_en", d), o_ae, int'(accum));
        chk($sformatf("d%0d_step_idx", d), o_si, accum ? age - 1 : 0);
        chk($sformatf("d%0d_owner_id", d), o_oi, m_owner[d]);
        chk($sformatf("d%0d_busy", d), o_b, int'(!idle));
        chk($sformatf("d%0d_done_valid", d), o_dv, int'(done));
        if (done) chk($sformatf("d%0d_done_id", d), o_di, m_owner[d]);
    endtask

    task automatic model_update(input int d, input logic rst, input bit acc, input int g, input bit rel);
        if (rst) begin
            m_start[d] = -1;
            m_rr[d]    = 0;
            m_owner[d] = 0;
        end else if (acc) begin
            m_start[d] = m_cyc;
            m_owner[d] = g;
            m_rr[d]    = (g + 1) % Np[d];
        end else if (rel) begin
            m_start[d] = -1;
        end
    endtask

    // One clock: drive on the falling edge, check, then advance the model at the rising edge.
    task automatic step(input logic [1:0] v0, input logic d0, input logic x0,
                        input logic v1, input logic d1, input logic x1);
        bit a0, a1, c0, c1;
        int g0, g1;
        @(negedge clk);
        rv0 = v0; dr0 = d0; rst0 = x0;
        rv1 = v1; dr1 = d1; rst1 = x1;
        #1;
        last_rr0 = rr0; last_ac0 = ac0; last_al0 = al0; last_si0 = si0;
        if (rr0 != 2'b00) q_gnt.push_back((rr0 == 2'b10) ? 1 : 0);
        model_eval(0, x0, int'(v0), d0, int'(rr0), int'(al0), int'(ac0), int'(ae0),
                   int'(si0), int'(oi0), int'(b0), int'(dv0), int'(di0), a0, g0, c0);
        model_eval(1, x1, int'(v1), d1, int'(rr1), int'(al1), int'(ac1), int'(ae1),
                   int'(si1), int'(oi1), int'(b1), int'(dv1), int'(di1), a1, g1, c1);
        @(posedge clk);
        model_update(0, x0, a0, g0, c0);
        model_update(1, x1, a1, g1, c1);
        m_cyc++;
    endtask

    initial begin
        rv0 = '0; dr0 = 1'b0; rst0 = 1'b1;
        rv1 = '0; dr1 = 1'b0; rst1 = 1'b1;
        repeat (2) @(posedge clk);
        m_start = '{-1, -1};
        m_owner = '{0, 0};
        m_rr    = '{0, 0};
        m_cyc   = 0;

        // Idle after reset: everything low.
        repeat (3) step(2'b00, 0, 0, 0, 0, 0);
        #1;
        chk("idle_busy", b0, 1'b0);
        chk("idle_done_valid", dv0, 1'b0);

        // Single job on each instance, fixed latency.
        step(2'b01, 0, 0, 1, 0, 0);
        chk("t037_req_ready", last_rr0, 2'b01);
        chk("t037_acc_clear", last_ac0, 1'b1);
        chk("t037_a_latch", last_al0, 1'b1);
        #1;
        chk("t041_acc_en_c1", ae1, 1'b1);
        chk("t041_step_c1", si1, 1'b0);
        step(2'b00, 0, 0, 0, 0, 0);
        #1;
        chk("t041_done_c2", dv1, 1'b1);
        chk("t041_acc_en_c2", ae1, 1'b0);
        repeat (3) step(2'b00, 0, 0, 0, 0, 0);
        #1;
        chk("t037_done_c5", dv0, 1'b1);
        chk("t037_done_id", di0, 1'b0);
        step(2'b00, 1, 0, 0, 1, 0);

        // Back-to-back jobs from two continuous requesters.
        step(2'b00, 0, 1, 0, 0, 1);
        q_gnt.delete();
        repeat (22) step(2'b11, 1, 0, 0, 0, 0);
        chk("t038_grants", q_gnt.size(), 5);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t038_gnt%0d", i), (i < q_gnt.size()) ? q_gnt[i] : -1, i % 2);

        // Consumer stalls the result while requester 1 waits.
        step(2'b00, 0, 1, 0, 0, 1);
        step(2'b10, 0, 0, 0, 0, 0);
        repeat (4) step(2'b10, 0, 0, 0, 0, 0);
        repeat (3) begin
            step(2'b10, 0, 0, 0, 0, 0);
            chk("t039_stall_ready", last_rr0, 2'b00);
        end
        step(2'b10, 1, 0, 0, 0, 0);
        chk("t039_ready", last_rr0, 2'b10);
        chk("t039_acc_clear", last_ac0, 1'b1);

        // Reset in the middle of accumulation.
        step(2'b00, 0, 1, 0, 0, 1);
        step(2'b01, 0, 0, 0, 0, 0);
        repeat (2) step(2'b00, 0, 0, 0, 0, 0);
        step(2'b00, 0, 1, 0, 0, 0);
        chk("t040_step_at_reset", last_si0, 2'd2);
        #1;
        chk("t040_busy", b0, 1'b0);
        chk("t040_acc_en", ae0, 1'b0);
        repeat (6) step(2'b00, 1, 0, 0, 0, 0);
        step(2'b10, 0, 0, 0, 0, 0);
        chk("t040_regrant", last_rr0, 2'b10);

        // Random traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            step(2'($urandom_range(0, 3)), 1'($urandom % 2), 1'($urandom % 50 == 0),
                 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 50 == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
